// File: rtl/switch_pkg.sv
// Shared constants, channel state type and match well-formedness check
// for the crossbar transfer scheduler.
package switch_pkg;

  localparam int PORTS   = 4;
  localparam int PORTS_W = $clog2(PORTS);
  localparam int LEN_W   = 11;

  typedef enum logic {
    CH_FREE = 1'b0,
    CH_XFER = 1'b1
  } ch_state_e;

  // Well-formed: every input row is zero or one-hot, and no output is granted twice.
  function automatic logic match_legal(input logic [PORTS*PORTS-1:0] vect);
    logic [PORTS-1:0] row;
    logic [PORTS-1:0] used;
    logic             ok;
    ok   = 1'b1;
    used = '0;
    for (int i = 0; i < PORTS; i++) begin
      row = vect[i*PORTS +: PORTS];
      if ((row & (row - PORTS'(1))) != '0) ok = 1'b0;
      if ((row & used) != '0)              ok = 1'b0;
      used = used | row;
    end
    return ok;
  endfunction

endpackage

// File: rtl/xfer_channel.sv
// One crossbar output channel: binds a source input for a packet and
// counts words down under back-pressure.
//   state   | meaning
//   CH_FREE | output unbound, waiting for a load from the acceptance logic
//   CH_XFER | output bound to src_q, cnt_q words still to move
module xfer_channel
  import switch_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [PORTS_W-1:0] load_src_i,
  input  logic [LEN_W-1:0]   load_len_i,
  input  logic               tx_rdy_i,
  output logic               en_o,
  output logic               last_o,
  output logic               busy_o,
  output logic [PORTS_W-1:0] src_o
);

  ch_state_e          state_q, state_d;
  logic [PORTS_W-1:0] src_q, src_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= CH_FREE;
      src_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    en_o    = 1'b0;
    last_o  = 1'b0;
    case (state_q)
      CH_FREE: begin
        if (load_i) begin
          state_d = CH_XFER;
          src_d   = load_src_i;
          // A zero-length head packet still moves one word.
          cnt_d   = (load_len_i == '0) ? LEN_W'(1) : load_len_i;
        end
      end
      CH_XFER: begin
        if (tx_rdy_i) begin
          en_o  = 1'b1;
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            last_o  = 1'b1;
            state_d = CH_FREE;
          end
        end
      end
      default: state_d = CH_FREE;
    endcase
  end

  assign busy_o = (state_q == CH_XFER);
  assign src_o  = src_q;

endmodule

// File: rtl/xbar_xfer_ctrl.sv
// Crossbar transfer scheduler: accepts whole arbiter matches, runs one
// channel per output and publishes busy masks back to the arbiter.
module xbar_xfer_ctrl
  import switch_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     match_valid_i,
  output logic                     match_ready_o,
  input  logic [PORTS*PORTS-1:0]   match_vect_i,
  input  logic [PORTS*LEN_W-1:0]   voq_len_i,
  input  logic [PORTS-1:0]         tx_rdy_vect_i,
  output logic [PORTS-1:0]         voq_rd_o,
  output logic [PORTS*PORTS_W-1:0] xbar_sel_o,
  output logic [PORTS-1:0]         xbar_en_o,
  output logic [PORTS-1:0]         xbar_last_o,
  output logic [PORTS-1:0]         in_busy_o,
  output logic [PORTS-1:0]         out_busy_o,
  output logic                     err_conflict_o
);

  logic               legal, pairs_free, zero_len, accept;
  logic [PORTS-1:0]   load, ch_busy, ch_en, ch_last;
  logic [PORTS_W-1:0] load_src [PORTS];
  logic [LEN_W-1:0]   load_len [PORTS];
  logic [PORTS_W-1:0] ch_src   [PORTS];

  // All-or-nothing acceptance: one busy port in any granted pair stalls the whole match.
  always_comb begin
    legal      = match_legal(match_vect_i);
    pairs_free = 1'b1;
    zero_len   = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      for (int j = 0; j < PORTS; j++) begin
        if (match_vect_i[i*PORTS+j]) begin
          if (in_busy_o[i] || ch_busy[j]) pairs_free = 1'b0;
          if (voq_len_i[i*LEN_W +: LEN_W] == '0) zero_len = 1'b1;
        end
      end
    end
    match_ready_o  = rst_ni & match_valid_i & (~legal | pairs_free);
    accept         = match_ready_o & legal;
    err_conflict_o = match_ready_o & (~legal | zero_len);
    for (int j = 0; j < PORTS; j++) begin
      load[j]     = 1'b0;
      load_src[j] = '0;
      for (int i = 0; i < PORTS; i++) begin
        if (match_vect_i[i*PORTS+j]) begin
          load[j]     = accept;
          load_src[j] = PORTS_W'(i);
        end
      end
      load_len[j] = voq_len_i[load_src[j]*LEN_W +: LEN_W];
    end
  end

  always_comb begin
    in_busy_o  = '0;
    voq_rd_o   = '0;
    xbar_sel_o = '0;
    for (int j = 0; j < PORTS; j++) begin
      if (ch_busy[j]) in_busy_o[ch_src[j]] = 1'b1;
      if (ch_en[j])   voq_rd_o[ch_src[j]]  = 1'b1;
      xbar_sel_o[j*PORTS_W +: PORTS_W] = ch_src[j];
    end
  end

  for (genvar j = 0; j < PORTS; j++) begin : g_ch
    xfer_channel u_ch (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (load[j]),
      .load_src_i (load_src[j]),
      .load_len_i (load_len[j]),
      .tx_rdy_i   (tx_rdy_vect_i[j]),
      .en_o       (ch_en[j]),
      .last_o     (ch_last[j]),
      .busy_o     (ch_busy[j]),
      .src_o      (ch_src[j])
    );
  end

  assign out_busy_o  = ch_busy;
  assign xbar_en_o   = ch_en;
  assign xbar_last_o = ch_last;

endmodule

// File: tb/tb_xbar_xfer_ctrl.sv
// Bench for xbar_xfer_ctrl: hand-derived vector table, directed corner
// sequences, and random traffic against a word-counting scoreboard.
module tb_xbar_xfer_ctrl;

  logic        clk;
  logic        rst_n;
  logic        mv, mr;
  logic [15:0] mvect;
  logic [43:0] vlen;
  logic [3:0]  tx, rd, en, last, ib, ob;
  logic [7:0]  sel;
  logic        err;

  int n_chk = 0;
  int n_err = 0;

  xbar_xfer_ctrl dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .match_valid_i  (mv),
    .match_ready_o  (mr),
    .match_vect_i   (mvect),
    .voq_len_i      (vlen),
    .tx_rdy_vect_i  (tx),
    .voq_rd_o       (rd),
    .xbar_sel_o     (sel),
    .xbar_en_o      (en),
    .xbar_last_o    (last),
    .in_busy_o      (ib),
    .out_busy_o     (ob),
    .err_conflict_o (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: per output, remaining words, bound input and whether bound.
  int   m_rem  [4];
  int   m_src  [4];
  bit   m_busy [4];
  logic p_rdy, p_err, mal;
  logic [3:0] p_en, p_last, p_rd, p_ib, p_ob;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int len_of(input logic [43:0] l, input int i);
    logic [10:0] v;
    v = l[i*11 +: 11];
    return int'(v);
  endfunction

  task automatic settle_check();
    logic [3:0] row;
    int  cc [4];
    logic ok, zl;
    #2;
    p_ib = '0; p_ob = '0; p_en = '0; p_last = '0; p_rd = '0;
    for (int j = 0; j < 4; j++) begin
      if (m_busy[j]) begin
        p_ob[j] = 1'b1;
        p_ib[m_src[j]] = 1'b1;
        if (tx[j]) begin
          p_en[j] = 1'b1;
          p_rd[m_src[j]] = 1'b1;
          if (m_rem[j] == 1) p_last[j] = 1'b1;
        end
      end
      cc[j] = 0;
    end
    mal = 1'b0; ok = 1'b1; zl = 1'b0;
    for (int i = 0; i < 4; i++) begin
      row = mvect[i*4 +: 4];
      if ($countones(row) > 1) mal = 1'b1;
      for (int j = 0; j < 4; j++) begin
        if (row[j]) begin
          cc[j]++;
          if (p_ob[j] || p_ib[i]) ok = 1'b0;
          if (len_of(vlen, i) == 0) zl = 1'b1;
        end
      end
    end
    for (int j = 0; j < 4; j++) if (cc[j] > 1) mal = 1'b1;
    p_rdy = rst_n && mv && (mal || ok);
    p_err = p_rdy && (mal || zl);
    chk("ready", mr, p_rdy);
    chk("err", err, p_err);
    chk("en", en, p_en);
    chk("last", last, p_last);
    chk("voq_rd", rd, p_rd);
    chk("out_busy", ob, p_ob);
    chk("in_busy", ib, p_ib);
    for (int j = 0; j < 4; j++)
      if (p_en[j]) chk("sel", sel[j*2 +: 2], m_src[j]);
  endtask

  task automatic advance();
    if (!rst_n) begin
      for (int j = 0; j < 4; j++) begin m_busy[j] = 0; m_rem[j] = 0; m_src[j] = 0; end
    end else begin
      for (int j = 0; j < 4; j++)
        if (p_en[j]) begin
          m_rem[j]--;
          if (m_rem[j] == 0) m_busy[j] = 0;
        end
      if (p_rdy && !mal)
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++)
            if (mvect[i*4+j]) begin
              m_busy[j] = 1;
              m_src[j]  = i;
              m_rem[j]  = (len_of(vlen, i) == 0) ? 1 : len_of(vlen, i);
            end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic v, input logic [15:0] vc,
                       input logic [43:0] l, input logic [3:0] t);
    rst_n = r; mv = v; mvect = vc; vlen = l; tx = t;
    settle_check();
  endtask

  task automatic drain();
    bit any;
    for (int k = 0; k < 3000; k++) begin
      any = 0;
      for (int j = 0; j < 4; j++) any |= m_busy[j];
      if (!any) break;
      drive(1'b1, 1'b0, 16'h0, vlen, 4'hF);
      advance();
    end
  endtask

  function automatic logic [15:0] gen_vect();
    logic [15:0] v;
    v = '0;
    if ($urandom_range(0, 9) == 0) return 16'($urandom);
    for (int i = 0; i < 4; i++)
      if ($urandom_range(0, 2) == 0) v[i*4 + int'($urandom_range(0, 3))] = 1'b1;
    return v;
  endfunction

  typedef struct {
    logic        r, v;
    logic [15:0] vc;
    logic [43:0] l;
    logic [3:0]  t;
    logic        rdy, er;
    logic [3:0]  e_en, e_last, e_rd, e_ob, e_ib;
  } vec_t;

  localparam logic [43:0] TL = {11'd0, 11'd2, 11'd2, 11'd3};
  vec_t tbl [18];

  int waits, words, lasts;
  bit acc;
  logic [3:0] perm_ob [5];

  initial begin
    for (int j = 0; j < 4; j++) begin m_busy[j] = 0; m_rem[j] = 0; m_src[j] = 0; end
    rst_n = 1'b0; mv = 1'b0; mvect = '0; vlen = TL; tx = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    // Reset held with a legal match presented: nothing may be accepted.
    drive(1'b0, 1'b1, 16'h0004, TL, 4'hF);
    chk("rst_ready", mr, 1'b0);
    advance();

    tbl[0]  = '{1,1,16'h0004,TL,4'hF, 1,0,4'h0,4'h0,4'h0,4'h0,4'h0};
    tbl[1]  = '{1,0,16'h0000,TL,4'hF, 0,0,4'h4,4'h0,4'h1,4'h4,4'h1};
    tbl[2]  = '{1,0,16'h0000,TL,4'hF, 0,0,4'h4,4'h0,4'h1,4'h4,4'h1};
    tbl[3]  = '{1,0,16'h0000,TL,4'hF, 0,0,4'h4,4'h4,4'h1,4'h4,4'h1};
    tbl[4]  = '{1,1,16'h0004,TL,4'hF, 1,0,4'h0,4'h0,4'h0,4'h0,4'h0};
    tbl[5]  = '{1,0,16'h0000,TL,4'hF, 0,0,4'h4,4'h0,4'h1,4'h4,4'h1};
    tbl[6]  = '{1,1,16'h0002,TL,4'hB, 0,0,4'h0,4'h0,4'h0,4'h4,4'h1};
    tbl[7]  = '{1,1,16'h0040,TL,4'hB, 0,0,4'h0,4'h0,4'h0,4'h4,4'h1};
    tbl[8]  = '{1,0,16'h0000,TL,4'hF, 0,0,4'h4,4'h0,4'h1,4'h4,4'h1};
    tbl[9]  = '{1,0,16'h0000,TL,4'hF, 0,0,4'h4,4'h4,4'h1,4'h4,4'h1};
    tbl[10] = '{1,0,16'h0000,TL,4'hF, 0,0,4'h0,4'h0,4'h0,4'h0,4'h0};
    tbl[11] = '{1,1,16'h0044,TL,4'hF, 1,1,4'h0,4'h0,4'h0,4'h0,4'h0};
    tbl[12] = '{1,0,16'h0000,TL,4'hF, 0,0,4'h0,4'h0,4'h0,4'h0,4'h0};
    tbl[13] = '{1,1,16'h1000,TL,4'hF, 1,1,4'h0,4'h0,4'h0,4'h0,4'h0};
    tbl[14] = '{1,0,16'h0000,TL,4'hF, 0,0,4'h1,4'h1,4'h8,4'h1,4'h8};
    tbl[15] = '{1,0,16'h0000,TL,4'hF, 0,0,4'h0,4'h0,4'h0,4'h0,4'h0};
    tbl[16] = '{1,1,16'h0000,TL,4'hF, 1,0,4'h0,4'h0,4'h0,4'h0,4'h0};
    tbl[17] = '{1,0,16'h0000,TL,4'hF, 0,0,4'h0,4'h0,4'h0,4'h0,4'h0};

    for (int k = 0; k < 18; k++) begin
      drive(tbl[k].r, tbl[k].v, tbl[k].vc, tbl[k].l, tbl[k].t);
      chk($sformatf("tbl%0d_ready", k), mr, tbl[k].rdy);
      chk($sformatf("tbl%0d_err", k), err, tbl[k].er);
      chk($sformatf("tbl%0d_en", k), en, tbl[k].e_en);
      chk($sformatf("tbl%0d_last", k), last, tbl[k].e_last);
      chk($sformatf("tbl%0d_rd", k), rd, tbl[k].e_rd);
      chk($sformatf("tbl%0d_ob", k), ob, tbl[k].e_ob);
      chk($sformatf("tbl%0d_ib", k), ib, tbl[k].e_ib);
      if (tbl[k].e_en[2]) chk($sformatf("tbl%0d_sel2", k), sel[5:4], 2'd0);
      advance();
    end

    // Full permutation, lengths 1..4: outputs free in length order.
    perm_ob = '{4'hF, 4'hD, 4'hC, 4'h4, 4'h0};
    drive(1'b1, 1'b1, 16'h4812, {11'd4, 11'd3, 11'd2, 11'd1}, 4'hF);
    chk("perm_ready", mr, 1'b1);
    advance();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 16'h0, vlen, 4'hF);
      chk($sformatf("perm_ob%0d", k), ob, perm_ob[k]);
      if (k == 0) chk("perm_ib_full", ib, 4'hF);
      advance();
    end
    drain();

    // Blocking and reuse of out2 after a 5-word packet.
    drive(1'b1, 1'b1, 16'h0004, {11'd1, 11'd1, 11'd2, 11'd5}, 4'hF);
    chk("blk_first", mr, 1'b1);
    advance();
    waits = 0; acc = 0;
    for (int k = 0; k < 20 && !acc; k++) begin
      drive(1'b1, 1'b1, 16'h0040, {11'd1, 11'd1, 11'd2, 11'd5}, 4'hF);
      if (mr) acc = 1; else waits++;
      advance();
    end
    chk("blk_acc", acc, 1'b1);
    chk("blk_waits", waits, 5);
    drain();

    // Reset during word 2 of 4, then an identical match moves all 4 words.
    drive(1'b1, 1'b1, 16'h0004, {11'd1, 11'd1, 11'd1, 11'd4}, 4'hF);
    advance();
    drive(1'b1, 1'b0, 16'h0, vlen, 4'hF);
    advance();
    drive(1'b0, 1'b0, 16'h0, vlen, 4'hF);
    advance();
    drive(1'b1, 1'b0, 16'h0, vlen, 4'hF);
    chk("rst_en", en, 4'h0);
    chk("rst_ob", ob, 4'h0);
    chk("rst_ib", ib, 4'h0);
    advance();
    drive(1'b1, 1'b1, 16'h0004, {11'd1, 11'd1, 11'd1, 11'd4}, 4'hF);
    chk("rst_reaccept", mr, 1'b1);
    advance();
    words = 0; lasts = 0;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 1'b0, 16'h0, vlen, 4'hF);
      words += int'(en[2]);
      lasts += int'(last[2]);
      advance();
    end
    chk("rst_words", words, 4);
    chk("rst_lasts", lasts, 1);

    // Maximum length 2047 words, no wrap.
    drive(1'b1, 1'b1, 16'h0100, {11'd1, 11'd2047, 11'd1, 11'd1}, 4'hF);
    advance();
    words = 0; lasts = 0;
    for (int k = 0; k < 2100; k++) begin
      drive(1'b1, 1'b0, 16'h0, vlen, 4'hF);
      words += int'(en[0]);
      lasts += int'(last[0]);
      advance();
    end
    chk("max_words", words, 2047);
    chk("max_lasts", lasts, 1);

    // Random traffic against the scoreboard.
    for (int k = 0; k < 600; k++) begin
      drive(($urandom_range(0, 59) != 0), 1'($urandom), gen_vect(),
            {11'($urandom_range(0, 6)), 11'($urandom_range(0, 6)),
             11'($urandom_range(0, 6)), 11'($urandom_range(0, 6))},
            4'($urandom));
      advance();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/xbar_xfer_ctrl.md
Name: xbar_xfer_ctrl

Overview:
- Transfer scheduler between the iSLIP arbiter and the 4-port switch crossbar.
- Accepts an input->output match from the arbiter and holds each granted crossbar connection for the full packet length.
- Pops words from the input VOQs under output back-pressure and releases the connection after the last word.
- Publishes per-input and per-output busy masks so the arbiter excludes occupied ports from later rounds.

Parameters:
- PORTS, 4, number of switch ports (inputs = outputs)
- PORTS_W, $clog2(PORTS), width of a crossbar select field
- LEN_W, 11, packet length field width in words

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- match_valid  in  1  arbiter match available
- match_ready  out  1  match accepted this cycle when high with match_valid
- match_vect  in  PORTS*PORTS  bits [i*PORTS +: PORTS] = one-hot output granted to input i; 0 = no grant
- voq_len  in  PORTS*LEN_W  head-packet length in words, per input; valid while that input has a pending request
- tx_rdy_vect  in  PORTS  output j can take a word this cycle
- voq_rd  out  PORTS  pop one word from input i VOQ
- xbar_sel  out  PORTS*PORTS_W  input index driving output j
- xbar_en  out  PORTS  word on output j valid this cycle
- xbar_last  out  PORTS  word on output j is last of packet
- in_busy  out  PORTS  input i bound to a connection
- out_busy  out  PORTS  output j bound to a connection
- err_conflict  out  1  one-cycle pulse: malformed match dropped

Behaviour:
- Reset (rst=0 at a clk edge):
  - All outputs 0; all channels return to CH_FREE; counters cleared.
  - A transfer in progress is abandoned, with no resume after reset.
  - match_ready is held 0 during reset.
- Channel FSM, one per output j, states CH_FREE and CH_XFER:
  - CH_FREE -> CH_XFER on an accepted match granting j to input i. Latch src=i and cnt=voq_len[i].
  - CH_XFER, tx_rdy_vect[j]=1 drives in the same cycle: xbar_en[j]=1, voq_rd[src]=1, xbar_sel[j]=src, and cnt decrements.
  - CH_XFER -> CH_FREE in the cycle after the cycle with cnt==1 and tx_rdy high; that cycle also drives xbar_last[j]=1.
  - CH_XFER with tx_rdy_vect[j]=0: stall, no outputs asserted, cnt held.
  - xbar_sel[j] holds its last value while free; it is don't-care when xbar_en=0.
- Length rules:
  - voq_len=0 is treated as 1 word and raises err_conflict.
  - Maximum length is 2^LEN_W-1 words; no wrap.
- Match acceptance:
  - Malformed when any input row is not one-hot/zero, or two rows grant the same output.
  - Malformed + match_valid: match_ready=1 (consumed), no channel loaded, err_conflict pulses.
  - Otherwise match_ready=1 iff every granted pair (i,j) has in_busy[i]=0 and out_busy[j]=0; else 0 and the match waits.
  - match_ready depends combinationally on match_valid/match_vect and the busy state.
  - All-zero match_vect with match_valid: accepted, no effect.
  - Partial acceptance is not allowed: all pairs of a match load together or none do.
- Latency:
  - Match accepted in cycle N: busy bits set and first xbar_en possible in cycle N+1.
  - Last word in cycle M: busy bits clear in M+1, and a new match using those ports can be accepted in M+1.
- Busy masks are registered state: in_busy[i] = OR over j of (CH_XFER and src_j==i); out_busy[j] = (state_j==CH_XFER).
- Multiple channels run concurrently and independently; at most one channel per input, guaranteed by the acceptance rule.

Decomposition:
- Package switch_pkg:
  - Constants PORTS, PORTS_W, LEN_W.
  - Channel state enum {CH_FREE, CH_XFER}.
  - Function match_legal(match_vect) returning 1 for well-formed.
- Sub-module xfer_channel: one per output, generated PORTS times.
  - Holds FSM, src and cnt.
  - Inputs: load, load_src, load_len, tx_rdy.
  - Outputs: en, last, busy, src.
  - The top level does acceptance and the voq_rd OR-reduction.

Test Plan:
- Basic transfer: match in0->out2, voq_len[0]=3, tx_rdy all 1 -> xbar_en[2] high cycles N+1..N+3, xbar_sel[2]=0, voq_rd[0] 3 pulses, xbar_last[2] at N+3, busy clear at N+4.
- Back-pressure: same setup with tx_rdy_vect[2]=0 for 2 cycles mid-packet -> 3 words over 5 cycles, cnt held during stall, exactly one xbar_last.
- Full permutation: in0->out1, in1->out0, in2->out3, in3->out2, lengths 1/2/3/4 -> all four channels concurrent; out_busy clears in length order; in_busy=4'hF then drains to 0.
- Blocking/reuse: out2 busy for 5 words, new match in1->out2 presented -> match_ready=0 until the cycle after xbar_last[2], then accepted that cycle.
- Malformed: rows in0=4'h4, in1=4'h4 -> match_ready=1, err_conflict one pulse, no busy bit set. Also voq_len=0 -> 1-word transfer plus err pulse.
- Reset mid-transfer: rst=0 during word 2 of 4 -> next cycle all outputs 0, busy 0; after release, an identical match is accepted and transfers the full 4 words.
